mc_controller: RTL and testbench
================================

// Module: mc_controller
// PURPOSE
//  Multicycle MIPS main control FSM plus ALU-control decode; sits directly upstream of the ALU.
//  Sequences each instruction through fetch/decode/execute/memory/writeback states from the latched op/funct.
//  Drives datapath mux selects, write enables and the 3-bit alucont consumed by the ALU.
//  Takes the ALU zero flag back to resolve beq/bne.
// PARAMETERS
//  STW     4   state register width (12 states used, codes 0..11)
// PORTS
//  clk       in   1  system clock; all state updates on rising edge
//  reset     in   1  synchronous, active-high; forces state to FETCH
//  op        in   6  instr[31:26] from instruction register
//  funct     in   6  instr[5:0] from instruction register
//  zero      in   1  ALU zero flag (valid in BRANCH state)
//  pcen      out  1  PC register enable = pcwrite | (branch & take)
//  iord      out  1  0: mem addr=PC, 1: mem addr=ALUOut
//  memwrite  out  1  data memory write strobe
//  irwrite   out  1  instruction register load
//  regwrite  out  1  register file write strobe
//  regdst    out  1  0: dest rt, 1: dest rd
//  memtoreg  out  1  0: wb ALUOut, 1: wb MDR
//  alusrca   out  1  0: A=PC, 1: A=regA
//  alusrcb   out  2  00 regB, 01 const 4, 10 imm, 11 imm<<2 (sign-ext)
//  immzext   out  1  1: imm zero-extended (andi/ori), else sign-extended
//  pcsrc     out  2  00 ALU result, 01 ALUOut, 10 jump target
//  alucont   out  3  AND 000, OR 001, ADD 010, RAND 100, ROR 101, SUB 110, SLT 111
//  state     out  STW current state (debug/verification)
// BEHAVIOUR
//  States: FETCH0 DECODE1 MEMADR2 MEMRD3 MEMWB4 MEMWR5 EXEC6 ALUWB7 BRANCH8 IEXEC9 IWB10 JUMP11.
//  Reset: state=FETCH on next edge; outputs are Moore decode of state, so post-reset = FETCH values.
//  All outputs not listed for a state are 0 (alucont defaults ADD 010).
//  FETCH: irwrite=1, pcwrite=1, alusrcb=01, alucont=ADD, pcsrc=00 -> DECODE.
//  DECODE: alusrcb=11, alucont=ADD (branch target into ALUOut). Next by op:
//   lw 100011 / sw 101011 -> MEMADR; R 000000 -> EXEC if funct legal; beq 000100 / bne 000101 -> BRANCH;
//   addi 001000 / andi 001100 / ori 001101 / slti 001010 -> IEXEC; j 000010 -> JUMP; else -> FETCH.
//  Legal funct: add 100000, sub 100010, and 100100, or 100101, slt 101010; illegal -> FETCH (no writes).
//  MEMADR: alusrca=1, alusrcb=10, ADD -> MEMRD (lw) or MEMWR (sw).
//  MEMRD: iord=1 -> MEMWB. MEMWB: regwrite=1, memtoreg=1, regdst=0 -> FETCH.
//  MEMWR: iord=1, memwrite=1 -> FETCH.
//  EXEC: alusrca=1, alusrcb=00, alucont from funct -> ALUWB. ALUWB: regwrite=1, regdst=1 -> FETCH.
//  BRANCH: alusrca=1, alusrcb=00, SUB, pcsrc=01; take = zero (beq) / ~zero (bne); pcen combinational
//   on zero in this cycle (only Mealy path) -> FETCH.
//  IEXEC: alusrca=1, alusrcb=10, alucont ADD/AND/OR/SLT for addi/andi/ori/slti; immzext=1 for andi/ori -> IWB.
//  IWB: regwrite=1, regdst=0, memtoreg=0 -> FETCH. JUMP: pcsrc=10, pcwrite=1 -> FETCH.
//  op/funct sampled combinationally each cycle; IR holds them stable after FETCH (irwrite only in FETCH).
//  Latency (cycles incl. FETCH): lw 5, sw 4, R 4, I-type 4, beq/bne 3, j 3, illegal 2.
//  Reset mid-instruction: abandon at next edge, no write strobes after that edge; state=FETCH.
//  Unused state codes 12..15 -> FETCH, all strobes 0.
//  memwrite/regwrite/irwrite/pcen never asserted in same cycle as reset-driven FETCH entry except FETCH's own.
// TESTING
//  reset=1 two cycles, release -> state=0, irwrite=1, pcen=1, alusrcb=01, alucont=010.
//  op=100011 -> states 0,1,2,3,4,0; MEMWB regwrite=1 memtoreg=1; MEMRD iord=1.
//  op=000000 funct=100010 -> EXEC alucont=110, ALUWB regwrite=1 regdst=1; funct=000111 -> 0,1,0, no regwrite.
//  op=000100: BRANCH zero=1 -> pcen=1 pcsrc=01; zero=0 -> pcen=0; op=000101 inverse.
//  op=001101 (ori) -> IEXEC alucont=001 immzext=1, IWB regwrite=1 regdst=0; op=000010 -> JUMP pcsrc=10 pcen=1.
//  reset asserted in MEMWR (sw) -> next cycle state=0, memwrite=0; op=111111 -> DECODE then FETCH, no strobes.

Source files
------------

// File: rtl/mc_if.sv
// Control bus between the multicycle MIPS main controller and its datapath.
// The controller (master) receives the latched opcode/funct and the ALU zero
// flag, and drives every mux select, write strobe and the ALU operation code.
interface mc_if #(
    parameter int STW = 4
);
    logic [5:0]     op;
    logic [5:0]     funct;
    logic           zero;
    logic           pcen;
    logic           iord;
    logic           memwrite;
    logic           irwrite;
    logic           regwrite;
    logic           regdst;
    logic           memtoreg;
    logic           alusrca;
    logic [1:0]     alusrcb;
    logic           immzext;
    logic [1:0]     pcsrc;
    logic [2:0]     alucont;
    logic [STW-1:0] state;

    modport master (
        input  op, funct, zero,
        output pcen, iord, memwrite, irwrite, regwrite, regdst, memtoreg,
               alusrca, alusrcb, immzext, pcsrc, alucont, state
    );

    modport slave (
        output op, funct, zero,
        input  pcen, iord, memwrite, irwrite, regwrite, regdst, memtoreg,
               alusrca, alusrcb, immzext, pcsrc, alucont, state
    );
endinterface

// File: rtl/mc_controller.sv
// Multicycle MIPS main control FSM with ALU-control decode.
// Outputs are a Moore decode of the state register; the only Mealy path is
// pcen in BRANCH, which follows the ALU zero flag within the same cycle.
module mc_controller #(
    parameter int STW = 4
) (
    input  logic clk,
    input  logic reset,
    mc_if.master bus
);
    typedef enum logic [STW-1:0] {
        FETCH  = 'd0,
        DECODE = 'd1,
        MEMADR = 'd2,
        MEMRD  = 'd3,
        MEMWB  = 'd4,
        MEMWR  = 'd5,
        EXEC   = 'd6,
        ALUWB  = 'd7,
        BRANCH = 'd8,
        IEXEC  = 'd9,
        IWB    = 'd10,
        JUMP   = 'd11
    } state_t;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_SLTI = 6'b001010;
    localparam logic [5:0] OP_ANDI = 6'b001100;
    localparam logic [5:0] OP_ORI  = 6'b001101;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    state_t     state_reg, state_next;
    logic       pcwrite, branch, take;
    logic       funct_legal;
    logic [2:0] funct_alu;
    logic [2:0] imm_alu;
    logic       imm_zext;

    // State register; reset abandons any instruction in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= FETCH;
        end else begin
            state_reg <= state_next;
        end
    end

    // R-type funct decode: ALU operation and legality (illegal funct aborts).
    always_comb begin
        funct_legal = 1'b1;
        funct_alu   = ALU_ADD;
        case (bus.funct)
            6'b100000: funct_alu = ALU_ADD;
            6'b100010: funct_alu = ALU_SUB;
            6'b100100: funct_alu = ALU_AND;
            6'b100101: funct_alu = ALU_OR;
            6'b101010: funct_alu = ALU_SLT;
            default:   funct_legal = 1'b0;
        endcase
    end

    // I-type decode: ALU operation and zero-extension for the logical immediates.
    always_comb begin
        imm_alu  = ALU_ADD;
        imm_zext = 1'b0;
        case (bus.op)
            OP_ANDI: begin imm_alu = ALU_AND; imm_zext = 1'b1; end
            OP_ORI:  begin imm_alu = ALU_OR;  imm_zext = 1'b1; end
            OP_SLTI: imm_alu = ALU_SLT;
            default: imm_alu = ALU_ADD;
        endcase
    end

    // Next-state and Moore output decode; anything not set below stays inactive.
    always_comb begin
        state_next   = FETCH;
        pcwrite      = 1'b0;
        branch       = 1'b0;
        bus.iord     = 1'b0;
        bus.memwrite = 1'b0;
        bus.irwrite  = 1'b0;
        bus.regwrite = 1'b0;
        bus.regdst   = 1'b0;
        bus.memtoreg = 1'b0;
        bus.alusrca  = 1'b0;
        bus.alusrcb  = 2'b00;
        bus.immzext  = 1'b0;
        bus.pcsrc    = 2'b00;
        bus.alucont  = ALU_ADD;
        case (state_reg)
            FETCH: begin
                bus.irwrite = 1'b1;
                pcwrite     = 1'b1;
                bus.alusrcb = 2'b01;
                state_next  = DECODE;
            end
            DECODE: begin
                // Speculatively compute the branch target into ALUOut.
                bus.alusrcb = 2'b11;
                case (bus.op)
                    OP_LW, OP_SW:                      state_next = MEMADR;
                    OP_R:                              state_next = funct_legal ? EXEC : FETCH;
                    OP_BEQ, OP_BNE:                    state_next = BRANCH;
                    OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: state_next = IEXEC;
                    OP_J:                              state_next = JUMP;
                    default:                           state_next = FETCH;
                endcase
            end
            MEMADR: begin
                bus.alusrca = 1'b1;
                bus.alusrcb = 2'b10;
                state_next  = (bus.op == OP_SW) ? MEMWR : MEMRD;
            end
            MEMRD: begin
                bus.iord   = 1'b1;
                state_next = MEMWB;
            end
            MEMWB: begin
                bus.regwrite = 1'b1;
                bus.memtoreg = 1'b1;
            end
            MEMWR: begin
                bus.iord     = 1'b1;
                bus.memwrite = 1'b1;
            end
            EXEC: begin
                bus.alusrca = 1'b1;
                bus.alucont = funct_alu;
                state_next  = ALUWB;
            end
            ALUWB: begin
                bus.regwrite = 1'b1;
                bus.regdst   = 1'b1;
            end
            BRANCH: begin
                bus.alusrca = 1'b1;
                bus.alucont = ALU_SUB;
                bus.pcsrc   = 2'b01;
                branch      = 1'b1;
            end
            IEXEC: begin
                bus.alusrca = 1'b1;
                bus.alusrcb = 2'b10;
                bus.alucont = imm_alu;
                bus.immzext = imm_zext;
                state_next  = IWB;
            end
            IWB: begin
                bus.regwrite = 1'b1;
            end
            JUMP: begin
                bus.pcsrc = 2'b10;
                pcwrite   = 1'b1;
            end
            default: state_next = FETCH;
        endcase
    end

    // bne inverts the sense of the zero flag; pcen is the only Mealy output.
    assign take      = (bus.op == OP_BNE) ? ~bus.zero : bus.zero;
    assign bus.pcen  = pcwrite | (branch & take);
    assign bus.state = state_reg;
endmodule

// File: tb/tb_mc_controller.sv
// Testbench for mc_controller: a table of instructions, each expanded into
// per-cycle expected control words pushed to a scoreboard and popped as the
// DUT walks the states, plus hand-written reset and Mealy-branch sequences.
module tb_mc_controller;
    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    mc_if #(.STW(4)) bus ();

    mc_controller #(.STW(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct packed {
        logic [3:0] st;
        logic       pcen;
        logic       iord;
        logic       memwrite;
        logic       irwrite;
        logic       regwrite;
        logic       regdst;
        logic       memtoreg;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic       immzext;
        logic [1:0] pcsrc;
        logic [2:0] alucont;
    } obs_t;

    typedef struct {
        string       name;
        logic [5:0]  op;
        logic [5:0]  funct;
        logic        zero;
        int          n;
        logic [19:0] sts;   // state i in bits [4*i +: 4]
        logic [2:0]  alu;
        logic        iz;
        logic        take;
    } vec_t;

    vec_t vecs[$];
    obs_t sb[$];
    int   checks = 0;
    int   errors = 0;

    // Expected control word for one state, written from the state table.
    function automatic obs_t exp_obs(logic [3:0] st, logic [2:0] alu, logic iz, logic take);
        obs_t o;
        o = '0;
        o.st = st;
        o.alucont = 3'b010;
        case (st)
            4'd0:  begin o.pcen = 1'b1; o.irwrite = 1'b1; o.alusrcb = 2'b01; end
            4'd1:  o.alusrcb = 2'b11;
            4'd2:  begin o.alusrca = 1'b1; o.alusrcb = 2'b10; end
            4'd3:  o.iord = 1'b1;
            4'd4:  begin o.regwrite = 1'b1; o.memtoreg = 1'b1; end
            4'd5:  begin o.iord = 1'b1; o.memwrite = 1'b1; end
            4'd6:  begin o.alusrca = 1'b1; o.alucont = alu; end
            4'd7:  begin o.regwrite = 1'b1; o.regdst = 1'b1; end
            4'd8:  begin o.alusrca = 1'b1; o.alucont = 3'b110; o.pcsrc = 2'b01; o.pcen = take; end
            4'd9:  begin o.alusrca = 1'b1; o.alusrcb = 2'b10; o.alucont = alu; o.immzext = iz; end
            4'd10: o.regwrite = 1'b1;
            4'd11: begin o.pcsrc = 2'b10; o.pcen = 1'b1; end
            default: ;
        endcase
        return o;
    endfunction

    function automatic obs_t sample();
        obs_t o;
        o.st       = bus.state;
        o.pcen     = bus.pcen;
        o.iord     = bus.iord;
        o.memwrite = bus.memwrite;
        o.irwrite  = bus.irwrite;
        o.regwrite = bus.regwrite;
        o.regdst   = bus.regdst;
        o.memtoreg = bus.memtoreg;
        o.alusrca  = bus.alusrca;
        o.alusrcb  = bus.alusrcb;
        o.immzext  = bus.immzext;
        o.pcsrc    = bus.pcsrc;
        o.alucont  = bus.alucont;
        return o;
    endfunction

    function automatic string fmt(obs_t o);
        return $sformatf("st=%0d pcen=%b iord=%b mw=%b ir=%b rw=%b rd=%b m2r=%b asa=%b asb=%b iz=%b pcs=%b alu=%b",
                         o.st, o.pcen, o.iord, o.memwrite, o.irwrite, o.regwrite, o.regdst,
                         o.memtoreg, o.alusrca, o.alusrcb, o.immzext, o.pcsrc, o.alucont);
    endfunction

    task automatic add_vec(string name, logic [5:0] op, logic [5:0] funct, logic zero, int n,
                           logic [19:0] sts, logic [2:0] alu, logic iz, logic take);
        vec_t v;
        v.name = name; v.op = op; v.funct = funct; v.zero = zero; v.n = n;
        v.sts = sts; v.alu = alu; v.iz = iz; v.take = take;
        vecs.push_back(v);
    endtask

    // Pop one expected word and compare against the DUT mid-cycle.
    task automatic check_cycle(string name, int idx);
        obs_t exp_o, got_o;
        @(negedge clk);
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL %s cyc%0d: scoreboard empty, got %s", name, idx, fmt(sample()));
        end else begin
            exp_o = sb.pop_front();
            got_o = sample();
            if (got_o !== exp_o) begin
                errors++;
                $display("FAIL %s cyc%0d: got [%s] expected [%s]", name, idx, fmt(got_o), fmt(exp_o));
            end
        end
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
    endtask

    task automatic run_vec(vec_t v);
        bus.op    = v.op;
        bus.funct = v.funct;
        bus.zero  = v.zero;
        for (int i = 0; i < v.n; i++) begin
            sb.push_back(exp_obs(v.sts[4*i +: 4], v.alu, v.iz, v.take));
        end
        for (int i = 0; i < v.n; i++) begin
            check_cycle(v.name, i);
            advance();
        end
        $display("txn %-10s op=%b funct=%b zero=%b cycles=%0d", v.name, v.op, v.funct, v.zero, v.n);
    endtask

    // Watchdog so the bench always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        //       name         op          funct       z   n  states (st0 in LSB)                        alu     iz    take
        add_vec("lw",        6'b100011, 6'b000000, 0, 5, {4'd4, 4'd3, 4'd2, 4'd1, 4'd0},    3'b010, 1'b0, 1'b0);
        add_vec("sw",        6'b101011, 6'b000000, 0, 4, {4'd0, 4'd5, 4'd2, 4'd1, 4'd0},    3'b010, 1'b0, 1'b0);
        add_vec("sub",       6'b000000, 6'b100010, 0, 4, {4'd0, 4'd7, 4'd6, 4'd1, 4'd0},    3'b110, 1'b0, 1'b0);
        add_vec("add",       6'b000000, 6'b100000, 0, 4, {4'd0, 4'd7, 4'd6, 4'd1, 4'd0},    3'b010, 1'b0, 1'b0);
        add_vec("and",       6'b000000, 6'b100100, 0, 4, {4'd0, 4'd7, 4'd6, 4'd1, 4'd0},    3'b000, 1'b0, 1'b0);
        add_vec("or",        6'b000000, 6'b100101, 0, 4, {4'd0, 4'd7, 4'd6, 4'd1, 4'd0},    3'b001, 1'b0, 1'b0);
        add_vec("slt",       6'b000000, 6'b101010, 0, 4, {4'd0, 4'd7, 4'd6, 4'd1, 4'd0},    3'b111, 1'b0, 1'b0);
        add_vec("badfunct",  6'b000000, 6'b000111, 0, 2, {4'd0, 4'd0, 4'd0, 4'd1, 4'd0},    3'b010, 1'b0, 1'b0);
        add_vec("beq_z1",    6'b000100, 6'b000000, 1, 3, {4'd0, 4'd0, 4'd8, 4'd1, 4'd0},    3'b010, 1'b0, 1'b1);
        add_vec("beq_z0",    6'b000100, 6'b000000, 0, 3, {4'd0, 4'd0, 4'd8, 4'd1, 4'd0},    3'b010, 1'b0, 1'b0);
        add_vec("bne_z1",    6'b000101, 6'b000000, 1, 3, {4'd0, 4'd0, 4'd8, 4'd1, 4'd0},    3'b010, 1'b0, 1'b0);
        add_vec("bne_z0",    6'b000101, 6'b000000, 0, 3, {4'd0, 4'd0, 4'd8, 4'd1, 4'd0},    3'b010, 1'b0, 1'b1);
        add_vec("addi",      6'b001000, 6'b000000, 0, 4, {4'd0, 4'd10, 4'd9, 4'd1, 4'd0},   3'b010, 1'b0, 1'b0);
        add_vec("andi",      6'b001100, 6'b000000, 0, 4, {4'd0, 4'd10, 4'd9, 4'd1, 4'd0},   3'b000, 1'b1, 1'b0);
        add_vec("ori",       6'b001101, 6'b000000, 0, 4, {4'd0, 4'd10, 4'd9, 4'd1, 4'd0},   3'b001, 1'b1, 1'b0);
        add_vec("slti",      6'b001010, 6'b000000, 0, 4, {4'd0, 4'd10, 4'd9, 4'd1, 4'd0},   3'b111, 1'b0, 1'b0);
        add_vec("j",         6'b000010, 6'b000000, 0, 3, {4'd0, 4'd0, 4'd11, 4'd1, 4'd0},   3'b010, 1'b0, 1'b0);
        add_vec("badop",     6'b111111, 6'b000000, 0, 2, {4'd0, 4'd0, 4'd0, 4'd1, 4'd0},    3'b010, 1'b0, 1'b0);

        // Reset held two cycles, checked while still asserted, then released.
        bus.op    = 6'b000000;
        bus.funct = 6'b000000;
        bus.zero  = 1'b0;
        reset     = 1'b1;
        advance();
        advance();
        sb.push_back(exp_obs(4'd0, 3'b010, 1'b0, 1'b0));
        check_cycle("reset", 0);
        advance();
        reset = 1'b0;

        foreach (vecs[k]) begin
            run_vec(vecs[k]);
        end

        // sw interrupted by reset while in MEMWR: no memwrite after the edge.
        bus.op = 6'b101011;
        sb.push_back(exp_obs(4'd0, 3'b010, 1'b0, 1'b0));
        sb.push_back(exp_obs(4'd1, 3'b010, 1'b0, 1'b0));
        sb.push_back(exp_obs(4'd2, 3'b010, 1'b0, 1'b0));
        sb.push_back(exp_obs(4'd5, 3'b010, 1'b0, 1'b0));
        for (int i = 0; i < 3; i++) begin
            check_cycle("sw_rst", i);
            advance();
        end
        check_cycle("sw_rst", 3);
        reset = 1'b1;
        advance();
        sb.push_back(exp_obs(4'd0, 3'b010, 1'b0, 1'b0));
        check_cycle("sw_rst_after", 0);
        advance();
        reset = 1'b0;
        $display("txn %-10s op=%b reset asserted in MEMWR", "sw_rst", bus.op);

        // beq: pcen must follow zero combinationally inside BRANCH.
        bus.op   = 6'b000100;
        bus.zero = 1'b0;
        sb.push_back(exp_obs(4'd0, 3'b010, 1'b0, 1'b0));
        sb.push_back(exp_obs(4'd1, 3'b010, 1'b0, 1'b0));
        sb.push_back(exp_obs(4'd8, 3'b010, 1'b0, 1'b0));
        check_cycle("beq_mealy", 0);
        advance();
        check_cycle("beq_mealy", 1);
        advance();
        check_cycle("beq_mealy", 2);
        #1 bus.zero = 1'b1;
        #1;
        checks++;
        if (bus.pcen !== 1'b1) begin
            errors++;
            $display("FAIL beq_mealy_pcen: got pcen=%b expected 1 after zero rose", bus.pcen);
        end
        advance();
        bus.zero = 1'b0;
        $display("txn %-10s op=%b zero toggled 0->1 in BRANCH", "beq_mealy", bus.op);

        // Back in FETCH after the last instruction.
        sb.push_back(exp_obs(4'd0, 3'b010, 1'b0, 1'b0));
        check_cycle("final", 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
